// File: rtl/fp_pkg.sv
// -----------------------------------------------------------------------------
// fp_pkg
// Shared floating-point definitions for the PE datapath arithmetic units
// (adder today, multiplier and MAC later).
//   FP_EXP_W / FP_MANT_W : default exponent / stored-mantissa widths (float32)
//   FP_GRS_W             : guard/round/sticky bits carried below the mantissa
//   fp_class_e           : operand classification after unpacking
//   fp_classify()        : classify an operand from its field summaries
// Denormals are flushed, so an all-zero exponent always classifies as zero.
// -----------------------------------------------------------------------------
package fp_pkg;

  localparam int FP_EXP_W  = 8;
  localparam int FP_MANT_W = 23;
  localparam int FP_GRS_W  = 3;

  typedef enum logic [1:0] {
    FP_ZERO = 2'd0,
    FP_NORM = 2'd1,
    FP_INF  = 2'd2,
    FP_NAN  = 2'd3
  } fp_class_e;

  // Classify from "exponent all zero", "exponent all ones", "mantissa zero".
  function automatic fp_class_e fp_classify(input logic exp_zero,
                                            input logic exp_ones,
                                            input logic mant_zero);
    fp_class_e cls;
    case ({exp_zero, exp_ones})
      2'b10:   cls = FP_ZERO;
      2'b01:   cls = mant_zero ? FP_INF : FP_NAN;
      default: cls = FP_NORM;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/fp_lzc.sv
// -----------------------------------------------------------------------------
// fp_lzc
// Combinational leading-zero counter.
//   lzc_in  [WIDTH-1:0] : vector to scan, MSB first
//   lzc_cnt [CNT_W-1:0] : number of zeros above the highest set bit
//                         (WIDTH when lzc_in is all zero)
// -----------------------------------------------------------------------------
module fp_lzc #(
  parameter int WIDTH = 25,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] lzc_in,
  output logic [CNT_W-1:0] lzc_cnt
);

  // Scan from the LSB upwards so the highest set bit is the last one written.
  always_comb begin
    lzc_cnt = CNT_W'(WIDTH);
    for (int i = 0; i < WIDTH; i++) begin
      lzc_cnt = lzc_in[i] ? CNT_W'(WIDTH - 1 - i) : lzc_cnt;
    end
  end

endmodule

// File: rtl/add_fp_pipe.sv
// -----------------------------------------------------------------------------
// add_fp_pipe
// 3-stage pipelined floating-point adder/subtractor, round-to-nearest-even,
// denormals flushed to zero, valid/ready handshake on both sides.
//   clk, rst_n            : clock, synchronous active-low reset
//   in_valid/in_ready     : operand handshake
//   in_sub                : 1 -> a-b, 0 -> a+b
//   in_a, in_b [WIDTH]    : operands {sign, exp, mant}
//   out_valid/out_ready   : result handshake
//   out_sum [WIDTH]       : rounded result
//   out_overflow          : finite operands rounded to +/-inf
//   out_underflow         : nonzero result flushed to signed zero
//   out_invalid           : canonical qNaN produced
// Stage 1 unpacks, resolves special operands and aligns the smaller operand;
// stage 2 adds/subtracts magnitudes; stage 3 normalises, rounds and packs.
// The whole pipe advances as one unit whenever the output slot is free.
// -----------------------------------------------------------------------------
module add_fp_pipe
  import fp_pkg::*;
#(
  parameter int EXP_W  = FP_EXP_W,
  parameter int MANT_W = FP_MANT_W,
  localparam int WIDTH = 1 + EXP_W + MANT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sub,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_overflow,
  output logic             out_underflow,
  output logic             out_invalid
);

  localparam int EXT_W = MANT_W + 1 + FP_GRS_W;  // hidden + mantissa + GRS
  localparam int SUM_W = EXT_W + 1;              // plus carry-out
  localparam int LZC_W = MANT_W + 2;             // hidden + mantissa + guard
  localparam int CNT_W = $clog2(LZC_W + 1);
  localparam int XE_W  = EXP_W + 2;              // signed exponent headroom

  localparam logic [EXP_W-1:0] EXP_ONES = {EXP_W{1'b1}};
  localparam logic [WIDTH-1:0] QNAN     = {1'b0, EXP_ONES, 1'b1, {(MANT_W-1){1'b0}}};

  logic advance_s;

  // Stage registers
  logic             s1_valid_q, s1_valid_d, s1_spec_q, s1_spec_d, s1_inv_q, s1_inv_d;
  logic             s1_sign_q, s1_sign_d, s1_eff_sub_q, s1_eff_sub_d;
  logic [WIDTH-1:0] s1_spec_val_q, s1_spec_val_d;
  logic [EXP_W-1:0] s1_exp_q, s1_exp_d;
  logic [EXT_W-1:0] s1_big_q, s1_big_d, s1_small_q, s1_small_d;

  logic             s2_valid_q, s2_valid_d, s2_spec_q, s2_spec_d, s2_inv_q, s2_inv_d;
  logic             s2_sign_q, s2_sign_d;
  logic [WIDTH-1:0] s2_spec_val_q, s2_spec_val_d;
  logic [EXP_W-1:0] s2_exp_q, s2_exp_d;
  logic [SUM_W-1:0] s2_sum_q, s2_sum_d;

  logic             s3_valid_q, s3_valid_d, s3_ovf_q, s3_ovf_d;
  logic             s3_unf_q, s3_unf_d, s3_inv_q, s3_inv_d;
  logic [WIDTH-1:0] s3_sum_q, s3_sum_d;

  // Stage 1 combinational
  logic              a_sign_s, b_sign_s, swap_s, big_sign_s, small_sign_s;
  logic [EXP_W-1:0]  a_exp_s, b_exp_s, big_exp_s, small_exp_s, exp_diff_s;
  logic [MANT_W-1:0] a_man_s, b_man_s, big_man_s, small_man_s;
  logic [EXT_W-1:0]  small_ext_s, small_shr_s, lost_mask_s;
  logic              sticky_s;
  fp_class_e         a_cls_s, b_cls_s;

  // Stage 3 combinational
  logic              carry_s, lsb_s, guard_s, rest_s, rnd_up_s, rnd_carry_s, ovf_s, unf_s;
  logic [CNT_W-1:0]  lzc_cnt_s;
  logic [EXT_W-1:0]  norm_s;
  logic [XE_W-1:0]   exp_n_s, exp_f_s;
  logic [MANT_W+1:0] man_rnd_s;
  logic [MANT_W-1:0] frac_s;

  assign advance_s     = !s3_valid_q || out_ready;
  assign in_ready      = advance_s;
  assign out_valid     = s3_valid_q;
  assign out_sum       = s3_sum_q;
  assign out_overflow  = s3_ovf_q;
  assign out_underflow = s3_unf_q;
  assign out_invalid   = s3_inv_q;

  // Stage 1: unpack, resolve specials, order by magnitude, align the smaller operand.
  always_comb begin
    a_sign_s = in_a[WIDTH-1];
    b_sign_s = in_b[WIDTH-1] ^ in_sub;
    a_exp_s  = in_a[WIDTH-2:MANT_W];
    b_exp_s  = in_b[WIDTH-2:MANT_W];
    a_man_s  = in_a[MANT_W-1:0];
    b_man_s  = in_b[MANT_W-1:0];
    a_cls_s  = fp_classify(a_exp_s == {EXP_W{1'b0}}, a_exp_s == EXP_ONES,
                           a_man_s == {MANT_W{1'b0}});
    b_cls_s  = fp_classify(b_exp_s == {EXP_W{1'b0}}, b_exp_s == EXP_ONES,
                           b_man_s == {MANT_W{1'b0}});

    s1_valid_d    = in_valid;
    s1_spec_d     = 1'b1;
    s1_inv_d      = 1'b0;
    s1_spec_val_d = {WIDTH{1'b0}};
    if ((a_cls_s == FP_NAN) || (b_cls_s == FP_NAN) ||
        ((a_cls_s == FP_INF) && (b_cls_s == FP_INF) && (a_sign_s != b_sign_s))) begin
      s1_inv_d      = 1'b1;
      s1_spec_val_d = QNAN;
    end else if (a_cls_s == FP_INF) begin
      s1_spec_val_d = {a_sign_s, EXP_ONES, {MANT_W{1'b0}}};
    end else if (b_cls_s == FP_INF) begin
      s1_spec_val_d = {b_sign_s, EXP_ONES, {MANT_W{1'b0}}};
    end else if ((a_cls_s == FP_ZERO) && (b_cls_s == FP_ZERO)) begin
      s1_spec_val_d = {a_sign_s & b_sign_s, {(WIDTH-1){1'b0}}};
    end else if (a_cls_s == FP_ZERO) begin
      s1_spec_val_d = {b_sign_s, b_exp_s, b_man_s};
    end else if (b_cls_s == FP_ZERO) begin
      s1_spec_val_d = in_a;
    end else begin
      s1_spec_d = 1'b0;
    end

    // Compare {exp, mant} so the larger magnitude is always the minuend.
    swap_s = {b_exp_s, b_man_s} > {a_exp_s, a_man_s};
    if (swap_s) begin
      big_sign_s   = b_sign_s;
      big_exp_s    = b_exp_s;
      big_man_s    = b_man_s;
      small_sign_s = a_sign_s;
      small_exp_s  = a_exp_s;
      small_man_s  = a_man_s;
    end else begin
      big_sign_s   = a_sign_s;
      big_exp_s    = a_exp_s;
      big_man_s    = a_man_s;
      small_sign_s = b_sign_s;
      small_exp_s  = b_exp_s;
      small_man_s  = b_man_s;
    end

    // Bits shifted below the sticky position collapse into it; a shift past the
    // whole field leaves only the sticky bit set.
    exp_diff_s  = big_exp_s - small_exp_s;
    small_ext_s = {1'b1, small_man_s, {FP_GRS_W{1'b0}}};
    small_shr_s = small_ext_s >> exp_diff_s;
    lost_mask_s = ~({EXT_W{1'b1}} << exp_diff_s);
    sticky_s    = |(small_ext_s & lost_mask_s);

    s1_sign_d    = big_sign_s;
    s1_eff_sub_d = big_sign_s ^ small_sign_s;
    s1_exp_d     = big_exp_s;
    s1_big_d     = {1'b1, big_man_s, {FP_GRS_W{1'b0}}};
    s1_small_d   = {small_shr_s[EXT_W-1:1], small_shr_s[0] | sticky_s};
  end

  // Stage 2: magnitude add or subtract; the swap keeps the difference non-negative.
  always_comb begin
    s2_valid_d    = s1_valid_q;
    s2_spec_d     = s1_spec_q;
    s2_inv_d      = s1_inv_q;
    s2_spec_val_d = s1_spec_val_q;
    s2_sign_d     = s1_sign_q;
    s2_exp_d      = s1_exp_q;
    if (s1_eff_sub_q) begin
      s2_sum_d = {1'b0, s1_big_q} - {1'b0, s1_small_q};
    end else begin
      s2_sum_d = {1'b0, s1_big_q} + {1'b0, s1_small_q};
    end
  end

  // After alignment the leading one of a nonzero sum is never below the guard bit.
  fp_lzc #(
    .WIDTH (LZC_W),
    .CNT_W (CNT_W)
  ) u_lzc (
    .lzc_in  (s2_sum_q[EXT_W-1:FP_GRS_W-1]),
    .lzc_cnt (lzc_cnt_s)
  );

  // Stage 3: normalise, round to nearest even, detect range limits, pack.
  always_comb begin
    carry_s = s2_sum_q[SUM_W-1];
    if (carry_s) begin
      norm_s  = {s2_sum_q[SUM_W-1:2], |s2_sum_q[1:0]};
      exp_n_s = {2'b00, s2_exp_q} + {{(XE_W-1){1'b0}}, 1'b1};
    end else begin
      norm_s  = s2_sum_q[EXT_W-1:0] << lzc_cnt_s;
      exp_n_s = {2'b00, s2_exp_q} - XE_W'(lzc_cnt_s);
    end

    lsb_s       = norm_s[FP_GRS_W];
    guard_s     = norm_s[FP_GRS_W-1];
    rest_s      = |norm_s[FP_GRS_W-2:0];
    rnd_up_s    = guard_s & (rest_s | lsb_s);
    man_rnd_s   = {1'b0, norm_s[EXT_W-1:FP_GRS_W]} + {{(MANT_W+1){1'b0}}, rnd_up_s};
    rnd_carry_s = man_rnd_s[MANT_W+1];
    frac_s      = rnd_carry_s ? man_rnd_s[MANT_W:1] : man_rnd_s[MANT_W-1:0];
    exp_f_s     = exp_n_s + {{(XE_W-1){1'b0}}, rnd_carry_s};
    // exp_f_s is two's complement: the MSB marks a negative exponent.
    ovf_s       = !exp_f_s[XE_W-1] && (exp_f_s >= {2'b00, EXP_ONES});
    unf_s       = exp_f_s[XE_W-1] || (exp_f_s == {XE_W{1'b0}});

    s3_valid_d = s2_valid_q;
    s3_sum_d   = {WIDTH{1'b0}};
    s3_ovf_d   = 1'b0;
    s3_unf_d   = 1'b0;
    s3_inv_d   = 1'b0;
    if (!s2_valid_q) begin
      s3_sum_d = {WIDTH{1'b0}};
    end else if (s2_spec_q) begin
      s3_sum_d = s2_spec_val_q;
      s3_inv_d = s2_inv_q;
    end else if (s2_sum_q == {SUM_W{1'b0}}) begin
      s3_sum_d = {WIDTH{1'b0}};  // exact cancellation gives +0
    end else if (ovf_s) begin
      s3_sum_d = {s2_sign_q, EXP_ONES, {MANT_W{1'b0}}};
      s3_ovf_d = 1'b1;
    end else if (unf_s) begin
      s3_sum_d = {s2_sign_q, {(WIDTH-1){1'b0}}};
      s3_unf_d = 1'b1;
    end else begin
      s3_sum_d = {s2_sign_q, exp_f_s[EXP_W-1:0], frac_s};
    end
  end

  // Pipeline registers: cleared on reset, loaded together on advance, held otherwise.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q    <= 1'b0;
      s1_spec_q     <= 1'b0;
      s1_inv_q      <= 1'b0;
      s1_sign_q     <= 1'b0;
      s1_eff_sub_q  <= 1'b0;
      s1_spec_val_q <= {WIDTH{1'b0}};
      s1_exp_q      <= {EXP_W{1'b0}};
      s1_big_q      <= {EXT_W{1'b0}};
      s1_small_q    <= {EXT_W{1'b0}};
      s2_valid_q    <= 1'b0;
      s2_spec_q     <= 1'b0;
      s2_inv_q      <= 1'b0;
      s2_sign_q     <= 1'b0;
      s2_spec_val_q <= {WIDTH{1'b0}};
      s2_exp_q      <= {EXP_W{1'b0}};
      s2_sum_q      <= {SUM_W{1'b0}};
      s3_valid_q    <= 1'b0;
      s3_ovf_q      <= 1'b0;
      s3_unf_q      <= 1'b0;
      s3_inv_q      <= 1'b0;
      s3_sum_q      <= {WIDTH{1'b0}};
    end else if (advance_s) begin
      s1_valid_q    <= s1_valid_d;
      s1_spec_q     <= s1_spec_d;
      s1_inv_q      <= s1_inv_d;
      s1_sign_q     <= s1_sign_d;
      s1_eff_sub_q  <= s1_eff_sub_d;
      s1_spec_val_q <= s1_spec_val_d;
      s1_exp_q      <= s1_exp_d;
      s1_big_q      <= s1_big_d;
      s1_small_q    <= s1_small_d;
      s2_valid_q    <= s2_valid_d;
      s2_spec_q     <= s2_spec_d;
      s2_inv_q      <= s2_inv_d;
      s2_sign_q     <= s2_sign_d;
      s2_spec_val_q <= s2_spec_val_d;
      s2_exp_q      <= s2_exp_d;
      s2_sum_q      <= s2_sum_d;
      s3_valid_q    <= s3_valid_d;
      s3_ovf_q      <= s3_ovf_d;
      s3_unf_q      <= s3_unf_d;
      s3_inv_q      <= s3_inv_d;
      s3_sum_q      <= s3_sum_d;
    end
  end

endmodule

// File: tb/tb_add_fp_pipe.sv
// -----------------------------------------------------------------------------
// tb_add_fp_pipe
// Directed self-checking bench for add_fp_pipe: a float32 instance and a
// half-precision (EXP_W=5, MANT_W=10) instance. Expected values are
// hand-computed IEEE-754 encodings; flags are packed {overflow,underflow,invalid}.
// -----------------------------------------------------------------------------
module tb_add_fp_pipe;

  logic        clk;
  logic        rst_n;
  logic        in_valid, in_ready, in_sub, out_valid, out_ready;
  logic [31:0] in_a, in_b, out_sum;
  logic        out_overflow, out_underflow, out_invalid;

  logic        h_in_valid, h_in_ready, h_in_sub, h_out_valid, h_out_ready;
  logic [15:0] h_in_a, h_in_b, h_out_sum;
  logic        h_out_overflow, h_out_underflow, h_out_invalid;

  int n_chk;
  int n_bad;

  logic [31:0] bp_a [4];
  logic [31:0] bp_b [4];
  logic [31:0] bp_e [4];

  add_fp_pipe u_dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_sub        (in_sub),
    .in_a          (in_a),
    .in_b          (in_b),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_sum       (out_sum),
    .out_overflow  (out_overflow),
    .out_underflow (out_underflow),
    .out_invalid   (out_invalid)
  );

  add_fp_pipe #(.EXP_W(5), .MANT_W(10)) u_dut_h (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (h_in_valid),
    .in_ready      (h_in_ready),
    .in_sub        (h_in_sub),
    .in_a          (h_in_a),
    .in_b          (h_in_b),
    .out_valid     (h_out_valid),
    .out_ready     (h_out_ready),
    .out_sum       (h_out_sum),
    .out_overflow  (h_out_overflow),
    .out_underflow (h_out_underflow),
    .out_invalid   (h_out_invalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp_v);
    n_chk++;
    if (got !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp_v);
    end
  endtask

  // One isolated operation: checks latency, result, flags, then the idle cycle after.
  task automatic do_op(input string tag, input bit half, input logic [31:0] a,
                       input logic [31:0] b, input logic sub,
                       input logic [31:0] exp_sum, input logic [2:0] exp_flg);
    int          n;
    logic [31:0] got;
    logic [2:0]  flg;
    @(negedge clk);
    if (half) begin
      h_in_valid = 1'b1; h_in_a = a[15:0]; h_in_b = b[15:0]; h_in_sub = sub;
    end else begin
      in_valid = 1'b1; in_a = a; in_b = b; in_sub = sub;
    end
    @(posedge clk); #1;
    in_valid   = 1'b0;
    h_in_valid = 1'b0;
    n = 1;
    while (!(half ? h_out_valid : out_valid) && n < 8) begin
      @(posedge clk); #1;
      n++;
    end
    got = half ? {16'h0000, h_out_sum} : out_sum;
    flg = half ? {h_out_overflow, h_out_underflow, h_out_invalid}
               : {out_overflow, out_underflow, out_invalid};
    check_val({tag, "_lat"}, n, 32'd3);
    check_val({tag, "_sum"}, got, exp_sum);
    check_val({tag, "_flg"}, {29'd0, flg}, {29'd0, exp_flg});
    @(posedge clk); #1;
    flg = half ? {h_out_overflow, h_out_underflow, h_out_invalid}
               : {out_overflow, out_underflow, out_invalid};
    check_val({tag, "_idle"}, {28'd0, (half ? h_out_valid : out_valid), flg}, 32'd0);
  endtask

  initial begin
    int sent;
    int got_n;
    int leaked;
    logic acc;

    n_chk = 0; n_bad = 0;
    rst_n = 1'b0;
    in_valid = 1'b0; in_sub = 1'b0; in_a = 32'd0; in_b = 32'd0; out_ready = 1'b1;
    h_in_valid = 1'b0; h_in_sub = 1'b0; h_in_a = 16'd0; h_in_b = 16'd0; h_out_ready = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check_val("rst_out_sum", out_sum, 32'd0);
    check_val("rst_flags", {29'd0, out_overflow, out_underflow, out_invalid}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check_val("rst_in_ready", {31'd0, in_ready}, 32'd1);

    // Float32 directed vectors
    do_op("add",       1'b0, 32'h3FC00000, 32'h3E800000, 1'b0, 32'h3FE00000, 3'b000);
    do_op("sub",       1'b0, 32'h3FC00000, 32'h40200000, 1'b1, 32'hBF800000, 3'b000);
    do_op("cancel",    1'b0, 32'hC3FA0F5C, 32'h43FA0F5C, 1'b0, 32'h00000000, 3'b000);
    do_op("plus_zero", 1'b0, 32'h40A00000, 32'h00000000, 1'b0, 32'h40A00000, 3'b000);
    do_op("denorm",    1'b0, 32'h00000001, 32'h00000000, 1'b0, 32'h00000000, 3'b000);
    do_op("ovf",       1'b0, 32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 3'b100);
    do_op("inf_inf",   1'b0, 32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 3'b001);
    do_op("rne_even",  1'b0, 32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 3'b000);
    do_op("rne_up",    1'b0, 32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 3'b000);
    do_op("rnd_carry", 1'b0, 32'h3FFFFFFF, 32'h33800000, 1'b0, 32'h40000000, 3'b000);
    do_op("rnd_ovf",   1'b0, 32'h7F7FFFFF, 32'h73000000, 1'b0, 32'h7F800000, 3'b100);
    do_op("mixed",     1'b0, 32'h40000000, 32'hBF800000, 1'b0, 32'h3F800000, 3'b000);
    do_op("swap",      1'b0, 32'h3F800000, 32'hC0400000, 1'b0, 32'hC0000000, 3'b000);
    do_op("unf",       1'b0, 32'h00800001, 32'h00800000, 1'b1, 32'h00000000, 3'b010);
    do_op("inf_fin",   1'b0, 32'hFF800000, 32'h3F800000, 1'b0, 32'hFF800000, 3'b000);
    do_op("nan_in",    1'b0, 32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, 3'b001);
    do_op("zero_sub",  1'b0, 32'h00000000, 32'h3F800000, 1'b1, 32'hBF800000, 3'b000);
    do_op("neg_zero",  1'b0, 32'h80000000, 32'h00000000, 1'b1, 32'h80000000, 3'b000);

    // Half-precision instance
    do_op("h_add",     1'b1, 32'h3E00, 32'h3400, 1'b0, 32'h3F00, 3'b000);
    do_op("h_sub",     1'b1, 32'h3E00, 32'h4100, 1'b1, 32'hBC00, 3'b000);
    do_op("h_ovf",     1'b1, 32'h7BFF, 32'h7BFF, 1'b0, 32'h7C00, 3'b100);
    do_op("h_inf_inf", 1'b1, 32'h7C00, 32'h7C00, 1'b1, 32'h7E00, 3'b001);

    // Backpressure: 4 back-to-back ops, consumer stalls for the first 5 cycles
    bp_a[0] = 32'h3FC00000; bp_b[0] = 32'h3E800000; bp_e[0] = 32'h3FE00000;
    bp_a[1] = 32'h40000000; bp_b[1] = 32'hBF800000; bp_e[1] = 32'h3F800000;
    bp_a[2] = 32'h3F800000; bp_b[2] = 32'hC0400000; bp_e[2] = 32'hC0000000;
    bp_a[3] = 32'h40A00000; bp_b[3] = 32'h00000000; bp_e[3] = 32'h40A00000;
    sent = 0; got_n = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(negedge clk);
      out_ready = (cyc >= 5);
      in_sub    = 1'b0;
      if (sent < 4) begin
        in_valid = 1'b1; in_a = bp_a[sent]; in_b = bp_b[sent];
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (cyc == 3 || cyc == 4) begin
        check_val("bp_in_ready", {31'd0, in_ready}, 32'd0);
        check_val("bp_sent", sent, 32'd3);
        check_val("bp_hold_sum", out_sum, bp_e[0]);
      end
      if (out_valid && out_ready) begin
        if (got_n < 4) check_val("bp_order", out_sum, bp_e[got_n]);
        got_n++;
      end
      acc = in_valid && in_ready;
      @(posedge clk);
      if (acc) sent++;
    end
    check_val("bp_count", got_n, 32'd4);

    // Reset with two ops in flight: nothing may come out afterwards
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1; in_sub = 1'b0;
    in_a = 32'h3FC00000; in_b = 32'h3E800000;
    @(negedge clk);
    in_a = 32'h40000000; in_b = 32'hBF800000;
    @(negedge clk);
    in_valid = 1'b0; rst_n = 1'b0;
    @(posedge clk); #1;
    check_val("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    check_val("mid_rst_sum", out_sum, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    leaked = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (out_valid) leaked++;
    end
    check_val("mid_rst_leak", leaked, 32'd0);
    check_val("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
